uart_tx_fifo: RTL and testbench

Byte queue sitting directly upstream of `uart_tx`. Accepts bytes from the host side over a valid/ready handshake, buffers up to DEPTH bytes, and launches them one at a time into `uart_tx` with a one-cycle `start` pulse, waiting for each frame to finish before launching the next. Lets software or a packet source burst bytes without pacing itself to the baud rate.

---
 rtl/uart_tx_fifo.sv | 73 +++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue that feeds uart_tx one frame at a time via a start pulse.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          tx_start_o,
    output logic [7:0]    tx_data_o,
    input  logic          tx_busy_i,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          overflow_o,
    input  logic          clr_ovf_i
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    data_q;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop;

    assign in_ready_o = count_q != FULL;
    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign tx_start_o = state_q == S_START;
    assign tx_data_o  = data_q;
    assign overflow_o = ovf_q;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = state_q == S_IDLE && !empty_o && !tx_busy_i;

    always_comb begin
        state_d = (state_q == S_IDLE)      ? (pop ? S_START : S_IDLE) :
                  (state_q == S_START)     ? S_WAIT_BUSY :
                  (state_q == S_WAIT_BUSY) ? (tx_busy_i ? S_WAIT_DONE : S_WAIT_BUSY) :
                                             (tx_busy_i ? S_WAIT_DONE : S_IDLE);
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ovf_d   = clr_ovf_i ? 1'b0 : (in_valid_i && !in_ready_o) ? 1'b1 : ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            data_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= push ? wp_q + AW'(1) : wp_q;
            rp_q    <= pop ? rp_q + AW'(1) : rp_q;
            count_q <= count_d;
            data_q  <= pop ? mem_q[rp_q] : data_q;
            ovf_q   <= ovf_d;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (rst_i && push) mem_q[wp_q] <= in_data_i;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench with a queue-based reference model and a stub uart_tx.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic [AW:0]   count;
    logic          empty;
    logic          overflow;
    logic          clr_ovf = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .tx_start_o(tx_start), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy), .count_o(count), .empty_o(empty),
        .overflow_o(overflow), .clr_ovf_i(clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a record of the frame currently owned by uart_tx.
    logic [7:0] q[$];
    bit         m_active = 0;
    bit         m_seen_hi = 0;
    int         m_edges = 0;
    bit         m_start = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 0;
    bit         cmp_en = 0;

    always @(posedge clk) begin
        bit can_pop;
        bit full;
        if (!rst) begin
            q.delete();
            m_active = 0;
            m_start  = 0;
            m_data   = 8'h00;
            m_ovf    = 0;
        end else begin
            full    = q.size() == DEPTH;
            can_pop = !m_active && q.size() > 0 && !tx_busy;
            m_ovf   = clr_ovf ? 0 : (in_valid && full) ? 1 : m_ovf;
            if (m_active) begin
                m_edges++;
                // the launch cycle itself ignores busy; afterwards a frame is busy rising then falling
                if (m_edges >= 2) begin
                    if (!m_seen_hi) m_seen_hi = tx_busy;
                    else if (!tx_busy) m_active = 0;
                end
            end
            m_start = can_pop;
            if (can_pop) begin
                m_data    = q.pop_front();
                m_active  = 1;
                m_seen_hi = 0;
                m_edges   = 0;
            end
            if (in_valid && !full) q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
            chk("tx_start", int'(tx_start), int'(m_start));
            chk("tx_data", int'(tx_data), int'(m_data));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    // Stub uart_tx: busy rises 0..2 cycles after start and lasts a random frame length.
    bit hold_busy = 0;
    bit long_frame = 0;
    bit frame_hi = 0;
    int dly = -1;
    int len = 0;
    int nstarts = 0;

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            nstarts++;
            dly = $urandom_range(0, 2);
            len = long_frame ? 40 : $urandom_range(3, 10);
        end
        if (dly == 0) begin
            frame_hi = 1;
            dly = -1;
        end else if (dly > 0) dly--;
        if (frame_hi) begin
            if (len == 0) frame_hi = 0;
            else len--;
        end
        tx_busy = hold_busy | frame_hi;
    end

    int peak = 0;

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m_active || tx_busy) && n < 2000) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
            n++;
        end
        chk("drain_bound", int'(n < 2000), 1);
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int s0;
        @(posedge clk);
        #1 cmp_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        rst = 1'b1;

        push(8'hB3);
        chk("b3_count", int'(count), 1);
        @(negedge clk);
        chk("b3_start", int'(tx_start), 1);
        chk("b3_data", int'(tx_data), 8'hB3);
        drain();
        chk("b3_data_held", int'(tx_data), 8'hB3);

        s0 = nstarts;
        peak = 0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        in_valid = 1'b0;
        drain();
        chk("burst_starts", nstarts - s0, 4);
        chk("burst_peak", peak, 3);

        hold_busy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_count", int'(count), 16);
        chk("full_in_ready", int'(in_ready), 0);
        push(8'hEE);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", int'(overflow), 0);

        hold_busy = 0;
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        long_frame = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_queued", int'(count), 5);
        chk("mid_busy", int'(tx_busy), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        s0 = nstarts;
        repeat (80) @(negedge clk);
        chk("mid_rst_no_start", nstarts - s0, 0);
        long_frame = 0;

        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) hold_busy = ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            clr_ovf  = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        hold_busy = 0;
        in_valid = 1'b0;
        clr_ovf = 1'b0;
        rst = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
